// File: rtl/ecc_62_pkg.sv
// ============================================================================
// Module : ecc_62_pkg
// Brief  : Shared constants for the 62-bit SECDED code (write encoder and
//          read-path decoder): data-to-position table, Hamming masks and
//          error-injection mode encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ecc_62_pkg;

  localparam int unsigned ECC_DATA_W   = 62;
  localparam int unsigned ECC_HAM_W    = 7;
  localparam int unsigned ECC_PARITY_W = 8;
  localparam int unsigned ECC_MAX_POS  = 69;

  // Error-injection modes (only meaningful when injection is built in)
  typedef enum logic [1:0] {
    INJ_NONE   = 2'b00,
    INJ_SINGLE = 2'b01,
    INJ_DOUBLE = 2'b10,
    INJ_RSVD   = 2'b11
  } inj_mode_e;

  typedef logic [ECC_HAM_W-1:0][ECC_DATA_W-1:0] par_mask_t;

  // Codeword position of data bit d: positions 1..69 with powers of two
  // reserved for check bits, data filling the rest in ascending order.
  function automatic int unsigned f_data_pos(input int unsigned d);
    int unsigned pos;
    int unsigned cnt;
    pos = 0;
    cnt = 0;
    for (int unsigned p = 1; p <= ECC_MAX_POS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == d) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // One mask per Hamming bit: data bits whose position has bit i set.
  function automatic par_mask_t f_par_masks();
    par_mask_t m;
    m = '0;
    for (int unsigned i = 0; i < ECC_HAM_W; i++) begin
      for (int unsigned d = 0; d < ECC_DATA_W; d++) begin
        if (((f_data_pos(d) >> i) & 1) != 0) m[i][d] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam par_mask_t PAR_MASK = f_par_masks();

endpackage

`default_nettype wire

// File: rtl/ecc_62_enc.sv
// ============================================================================
// Module : ecc_62_enc
// Brief  : Combinational SECDED encoder, 62 data bits -> 8 parity bits
//          (7 Hamming + overall). Bypass forces parity to zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ecc_62_enc
  import ecc_62_pkg::*;
(
  input  logic [ECC_DATA_W-1:0]   data_in,
  input  logic                    bypass,
  output logic [ECC_PARITY_W-1:0] parity_out
);

  logic [ECC_HAM_W-1:0] w_ham;
  logic                 w_overall;

  // Hamming bits: reduction XOR over each position-class mask
  always_comb begin
    for (int i = 0; i < ECC_HAM_W; i++) begin
      w_ham[i] = ^(data_in & PAR_MASK[i]);
    end
  end

  // Overall bit covers all data and all Hamming bits
  assign w_overall  = (^data_in) ^ (^w_ham);
  assign parity_out = bypass ? '0 : {w_overall, w_ham};

endmodule

`default_nettype wire

// File: rtl/ecc_62_enc_fault_detc.sv
// ============================================================================
// Module : ecc_62_enc_fault_detc
// Brief  : FIFO write-side SECDED encoder with two lockstep encoder copies.
//          A mismatch poisons the codeword (syndrome 3, overall unchanged)
//          so the read-path decoder flags a double-bit error; faults are
//          also flagged, made sticky and counted.
//          Optional macro ECC_62_ERR_INJ_EN adds post-encode data error
//          injection (inj_arm / inj_mode / inj_pos).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ecc_62_enc_fault_detc
  import ecc_62_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = ECC_DATA_W,
  parameter int unsigned PARITY_WIDTH = ECC_PARITY_W,
  parameter int unsigned FCNT_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ecc_fault_detc_en,
  input  logic                    bypass,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [PARITY_WIDTH-1:0] parity_out,
  output logic                    ecc_fault,
  output logic                    fault_sticky,
  output logic [FCNT_WIDTH-1:0]   fault_cnt,
  input  logic                    fault_clr
`ifdef ECC_62_ERR_INJ_EN
  ,
  input  logic                    inj_arm,
  input  logic [1:0]              inj_mode,
  input  logic [5:0]              inj_pos
`endif
);

  logic [PARITY_WIDTH-1:0] w_par0;
  logic [PARITY_WIDTH-1:0] w_par1;
  logic                    w_accept;
  logic                    w_mismatch;
  logic [PARITY_WIDTH-1:0] w_par_sel;
  logic [DATA_WIDTH-1:0]   w_data_cw;

  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [PARITY_WIDTH-1:0] r_parity;
  logic                    r_ecc_fault;
  logic                    r_sticky;
  logic [FCNT_WIDTH-1:0]   r_cnt;

  // Redundant encoders; only u0 drives the codeword, u1 is the checker copy
  ecc_62_enc u0 (
    .data_in    (data_in),
    .bypass     (bypass),
    .parity_out (w_par0)
  );

  ecc_62_enc u1 (
    .data_in    (data_in),
    .bypass     (bypass),
    .parity_out (w_par1)
  );

  assign in_ready   = ~r_out_valid | out_ready;
  assign w_accept   = in_valid & in_ready;
  assign w_mismatch = ecc_fault_detc_en & ~bypass & w_accept & (w_par0 != w_par1);

  // Poison flips check bits 1 and 2 (syndrome 3); overall parity untouched
  assign w_par_sel  = w_mismatch ? (w_par0 ^ {{(PARITY_WIDTH-2){1'b0}}, 2'b11}) : w_par0;

`ifdef ECC_62_ERR_INJ_EN
  logic                  r_inj_armed;
  inj_mode_e             r_inj_mode;
  logic [5:0]            r_inj_pos;
  logic [5:0]            w_inj_next;
  logic [DATA_WIDTH-1:0] w_inj_one;
  logic [DATA_WIDTH-1:0] w_inj_mask;

  assign w_inj_next = (r_inj_pos == 6'd61) ? 6'd0 : (r_inj_pos + 6'd1);
  assign w_inj_one  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  // Corruption pattern applied to the data after encoding
  always_comb begin
    w_inj_mask = '0;
    if (r_inj_armed && (r_inj_pos < 6'd62)) begin
      case (r_inj_mode)
        INJ_SINGLE: w_inj_mask = w_inj_one << r_inj_pos;
        INJ_DOUBLE: w_inj_mask = (w_inj_one << r_inj_pos) | (w_inj_one << w_inj_next);
        default:    w_inj_mask = '0;
      endcase
    end
  end

  assign w_data_cw = data_in ^ w_inj_mask;

  // Arm on pulse; consumed by the next accept (a same-cycle arm re-arms)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inj_armed <= 1'b0;
      r_inj_mode  <= INJ_NONE;
      r_inj_pos   <= '0;
    end else if (inj_arm) begin
      r_inj_armed <= 1'b1;
      r_inj_mode  <= inj_mode_e'(inj_mode);
      r_inj_pos   <= inj_pos;
    end else if (w_accept) begin
      r_inj_armed <= 1'b0;
    end
  end
`else
  assign w_data_cw = data_in;
`endif

  // Output register stage: load on accept, drain when downstream takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_parity    <= '0;
      r_ecc_fault <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_data      <= w_data_cw;
      r_parity    <= w_par_sel;
      r_ecc_fault <= w_mismatch;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_ecc_fault <= 1'b0;
    end
  end

  // Sticky flag and saturating counter; clear has priority over a new fault
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (fault_clr) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (w_mismatch) begin
      r_sticky <= 1'b1;
      if (r_cnt != {FCNT_WIDTH{1'b1}}) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid    = r_out_valid;
  assign data_out     = r_data;
  assign parity_out   = r_parity;
  assign ecc_fault    = r_ecc_fault;
  assign fault_sticky = r_sticky;
  assign fault_cnt    = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ecc_62_enc_fault_detc.sv
// ============================================================================
// Module : tb_ecc_62_enc_fault_detc
// Brief  : Self-checking bench for ecc_62_enc_fault_detc with a cycle-level
//          behavioural model, a behavioural SECDED decoder and literal pins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ecc_62_enc_fault_detc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        bypass = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [61:0] data_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [61:0] data_out;
  logic [7:0]  parity_out;
  logic        ecc_fault;
  logic        fault_sticky;
  logic [7:0]  fault_cnt;
  logic        fault_clr = 1'b0;
`ifdef ECC_62_ERR_INJ_EN
  logic        inj_arm = 1'b0;
  logic [1:0]  inj_mode = 2'b00;
  logic [5:0]  inj_pos = 6'd0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic check_on = 1'b0;
  logic force_on = 1'b0;

  always #5 clk = ~clk;

  ecc_62_enc_fault_detc dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ecc_fault_detc_en (en),
    .bypass            (bypass),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .data_in           (data_in),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .data_out          (data_out),
    .parity_out        (parity_out),
    .ecc_fault         (ecc_fault),
    .fault_sticky      (fault_sticky),
    .fault_cnt         (fault_cnt),
    .fault_clr         (fault_clr)
`ifdef ECC_62_ERR_INJ_EN
    ,
    .inj_arm           (inj_arm),
    .inj_mode          (inj_mode),
    .inj_pos           (inj_pos)
`endif
  );

  // ---------------- behavioural SECDED reference ----------------
  function automatic logic [7:0] f_enc(input logic [61:0] d);
    logic [6:0] syn = '0;
    logic       ov  = 1'b0;
    int         k   = 0;
    for (int p = 1; p <= 69; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) begin
          syn ^= 7'(p);
          ov  ^= 1'b1;
        end
        k++;
      end
    end
    ov ^= ^syn;
    return {ov, syn};
  endfunction

  // 0 = clean, 1 = single-bit, 2 = double-bit
  function automatic logic [1:0] f_dec(input logic [61:0] d, input logic [7:0] par);
    logic [6:0] syn = par[6:0];
    logic       ov  = (^d) ^ (^par);
    int         k   = 0;
    for (int p = 1; p <= 69; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) syn ^= 7'(p);
        k++;
      end
    end
    if (ov) return 2'd1;
    if (syn != 7'd0) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [61:0] f_correct(input logic [61:0] d, input logic [7:0] par);
    logic [6:0]  syn = par[6:0];
    logic [61:0] r   = d;
    int          k   = 0;
    for (int p = 1; p <= 69; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) syn ^= 7'(p);
        k++;
      end
    end
    k = 0;
    for (int p = 1; p <= 69; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (7'(p) == syn) r[k] = ~r[k];
        k++;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- cycle model of the output stage ----------------
  logic        m_valid, m_fault, m_sticky, m_byp, m_inj;
  logic [61:0] m_data;
  logic [7:0]  m_par;
  int          m_cnt;
`ifdef ECC_62_ERR_INJ_EN
  logic        a_armed;
  logic [1:0]  a_mode;
  int          a_pos;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_fault <= 1'b0; m_sticky <= 1'b0; m_byp <= 1'b0;
      m_inj <= 1'b0; m_data <= '0; m_par <= '0; m_cnt <= 0;
`ifdef ECC_62_ERR_INJ_EN
      a_armed <= 1'b0; a_mode <= 2'b00; a_pos <= 0;
`endif
    end else begin
      automatic logic        acc  = in_valid && (!m_valid || out_ready);
      automatic logic        mis  = acc && force_on && en && !bypass;
      automatic logic [7:0]  p    = bypass ? 8'h00 : f_enc(data_in);
      automatic logic [61:0] d    = data_in;
      automatic logic        injd = 1'b0;
`ifdef ECC_62_ERR_INJ_EN
      if (acc && a_armed && a_pos < 62) begin
        if (a_mode == 2'b01) begin d[a_pos] = ~d[a_pos]; injd = 1'b1; end
        if (a_mode == 2'b10) begin
          d[a_pos] = ~d[a_pos];
          d[(a_pos + 1) % 62] = ~d[(a_pos + 1) % 62];
          injd = 1'b1;
        end
      end
      if (inj_arm) begin
        a_armed <= 1'b1; a_mode <= inj_mode; a_pos <= int'(inj_pos);
      end else if (acc) begin
        a_armed <= 1'b0;
      end
`endif
      if (mis) p = p ^ 8'h03;
      if (acc) begin
        m_valid <= 1'b1; m_data <= d; m_par <= p; m_fault <= mis;
        m_byp <= bypass; m_inj <= injd;
      end else if (out_ready) begin
        m_valid <= 1'b0; m_fault <= 1'b0;
      end
      if (fault_clr) begin
        m_sticky <= 1'b0; m_cnt <= 0;
      end else if (mis) begin
        m_sticky <= 1'b1;
        m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
  end

  // Compare process: all outputs against the model each cycle
  always @(negedge clk) begin
    if (rst_n && check_on) begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      chk("data_out", 64'(data_out), 64'(m_data));
      chk("parity_out", 64'(parity_out), 64'(m_par));
      chk("ecc_fault", 64'(ecc_fault), 64'(m_fault));
      chk("fault_sticky", 64'(fault_sticky), 64'(m_sticky));
      chk("fault_cnt", 64'(fault_cnt), 64'(m_cnt));
      if (m_valid && !m_byp && !m_inj)
        chk("decode_status", 64'(f_dec(data_out, parity_out)), m_fault ? 64'd2 : 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [61:0] a, b;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_on = 1'b1;
    // reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_parity", 64'(parity_out), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_sticky_cnt", {55'd0, fault_sticky, fault_cnt}, 64'd0);

    // zero beat and single-one beat
    data_in = '0; in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("zero_valid", 64'(out_valid), 64'd1);
    chk("zero_parity", 64'(parity_out), 64'h00);
    chk("zero_fault", 64'(ecc_fault), 64'd0);
    data_in = 62'h1; in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("one_parity", 64'(parity_out), 64'h83);

    // backpressure: first beat held, second waits
    a = 62'(64'h1234_5678_9ABC_DEF0); b = 62'(64'h0FED_CBA9_8765_4321);
    step();
    out_ready = 1'b0; data_in = a; in_valid = 1'b1; step();
    data_in = b;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_data", 64'(data_out), 64'(a));
    end
    out_ready = 1'b1; step(); in_valid = 1'b0;
    chk("release_data", 64'(data_out), 64'(b));
    chk("release_parity", 64'(parity_out), 64'(f_enc(b)));
    step();

    // forced encoder mismatch on u1 bit 3
    data_in = 62'h1; in_valid = 1'b1; en = 1'b1;
    force dut.w_par1 = 8'h8B; force_on = 1'b1;
    step();
    release dut.w_par1; force_on = 1'b0; in_valid = 1'b0;
    chk("poison_parity", 64'(parity_out), 64'h80);
    chk("poison_fault", 64'(ecc_fault), 64'd1);
    chk("poison_sticky", 64'(fault_sticky), 64'd1);
    chk("poison_cnt", 64'(fault_cnt), 64'd1);
    chk("poison_dbit", 64'(f_dec(data_out, parity_out)), 64'd2);
    step();
    chk("fault_leaves", 64'(ecc_fault), 64'd0);

    // same with compare disabled
    en = 1'b0; in_valid = 1'b1;
    force dut.w_par1 = 8'h8B; force_on = 1'b1;
    step();
    release dut.w_par1; force_on = 1'b0; in_valid = 1'b0; en = 1'b1;
    chk("nodet_parity", 64'(parity_out), 64'h83);
    chk("nodet_fault", 64'(ecc_fault), 64'd0);
    chk("nodet_cnt", 64'(fault_cnt), 64'd1);

    // saturate counter
    in_valid = 1'b1; force dut.w_par1 = 8'h8B; force_on = 1'b1;
    repeat (300) step();
    chk("sat_cnt", 64'(fault_cnt), 64'd255);
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    release dut.w_par1; force_on = 1'b0; in_valid = 1'b0;
    chk("clr_win_sticky", 64'(fault_sticky), 64'd0);
    chk("clr_win_cnt", 64'(fault_cnt), 64'd0);
    chk("clr_win_beat_fault", 64'(ecc_fault), 64'd1);
    step();

    // randomized traffic
    for (int i = 0; i < 1000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      bypass    = ($urandom_range(0, 9) == 0);
      en        = ($urandom_range(0, 3) != 0);
      data_in   = 62'({$urandom(), $urandom()});
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; bypass = 1'b0; en = 1'b1;
    step();

    // asynchronous reset while holding a beat
    out_ready = 1'b0; in_valid = 1'b1; data_in = a; step(); in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_data", 64'(data_out), 64'd0);
    out_ready = 1'b1;
    step(); rst_n = 1'b1;
    step();

`ifdef ECC_62_ERR_INJ_EN
    inj_arm = 1'b1; inj_mode = 2'b01; inj_pos = 6'd5; step(); inj_arm = 1'b0;
    data_in = a; in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("inj1_data", 64'(data_out), 64'(a ^ 62'h20));
    chk("inj1_sbit", 64'(f_dec(data_out, parity_out)), 64'd1);
    chk("inj1_corr", 64'(f_correct(data_out, parity_out)), 64'(a));
    inj_arm = 1'b1; inj_mode = 2'b10; inj_pos = 6'd61; step(); inj_arm = 1'b0;
    data_in = b; in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("inj2_data", 64'(data_out), 64'(b ^ {1'b1, 60'd0, 1'b1}));
    chk("inj2_dbit", 64'(f_dec(data_out, parity_out)), 64'd2);
    data_in = b; in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("inj_selfclr", 64'(data_out), 64'(b));
    step();
`endif

    check_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ecc_62_enc_fault_detc.md
Name: ecc_62_enc_fault_detc

Overview:
Write-side counterpart of the FIFO ECC read-path checker. It accepts 62-bit data beats over a valid/ready handshake and computes the 8-bit SECDED parity with two redundant encoder instances. The two results are compared in lockstep. The codeword is registered toward the FIFO write port, and encoder mismatches are flagged, counted and poisoned so the read-path decoder reports a double-bit error.

Parameters:
DATA_WIDTH, 62, data bits per beat (only 62 supported)
PARITY_WIDTH, 8, SECDED check bits (7 Hamming + 1 overall)
FCNT_WIDTH, 8, width of saturating fault counter

Ports:
clk  input  1  single clock
rst_n  input  1  asynchronous active-low reset
ecc_fault_detc_en  input  1  enables lockstep compare
bypass  input  1  1 = parity forced to 0, no poisoning
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid&in_ready
data_in  input  DATA_WIDTH  data to encode
out_valid  output  1  codeword valid
out_ready  input  1  downstream accepts codeword
data_out  output  DATA_WIDTH  registered data
parity_out  output  PARITY_WIDTH  registered parity
ecc_fault  output  1  asserted with the out beat whose encoding mismatched
fault_sticky  output  1  set on any fault, held until fault_clr
fault_cnt  output  FCNT_WIDTH  saturating fault count
fault_clr  input  1  synchronous clear of fault_sticky and fault_cnt

Behaviour:
- Code: positions 1..69; check bits at 1,2,4,8,16,32,64; data bits fill the remaining positions in ascending order, data[0] at position 3. parity[i] (i=0..6) = XOR of data bits whose position has bit i set. parity[7] = XOR of all data bits and parity[6:0]. Identical to the read-path decoder's code.
- Single output register stage, latency 1. in_ready = ~out_valid | out_ready.
- On accept: data_out <= data_in, parity_out <= enc0 parity (or 0 if bypass), out_valid <= 1.
- Otherwise, if out_ready, out_valid <= 0.
- Held beat is stable while out_valid & ~out_ready.
- Mismatch = enc0 parity != enc1 parity, qualified by ecc_fault_detc_en & ~bypass & accept.
- On mismatch: parity_out <= enc0 parity with bits [1:0] inverted (poison: syndrome 3, overall parity unchanged, so the decoder sees a double-bit error). ecc_fault is registered with the beat and clears when the beat leaves.
- On mismatch, fault_sticky <= 1 and fault_cnt increments, saturating at 2^FCNT_WIDTH-1.
- fault_clr wins over a same-cycle fault: result is sticky 0, cnt 0.
- Reset values: out_valid=0, data_out=0, parity_out=0, ecc_fault=0, fault_sticky=0, fault_cnt=0. in_ready=1 after reset.
- Reset mid-transfer discards the held beat.
- ecc_fault_detc_en=0: no compare, no poisoning, counters hold.

Optional Feature:
Macro ECC_62_ERR_INJ_EN.
- When defined, adds ports inj_arm (in, 1), inj_mode (in, 2) and inj_pos (in, 6).
- An inj_arm pulse latches mode and pos into an armed register.
- On the next accepted beat, data_out is corrupted after encoding:
  - mode 01: flip data bit inj_pos.
  - mode 10: flip bits inj_pos and (inj_pos+1) mod 62.
  - Any other mode: no flip.
- The armed register then self-clears.
- inj_pos >= 62 is treated as no injection.
- inj_arm in the same cycle as an accept applies to the following beat.
- Without the macro: no ports, no logic, data_out is always unmodified.

Decomposition:
- Package ecc_62_pkg: DATA_WIDTH/PARITY_WIDTH constants, data-to-position table, parity mask constants (one 62-bit mask per Hamming bit), injection mode encodings. Shared with the read-path decoder.
- Sub-module ecc_62_enc: combinational encoder (data_in, bypass -> parity_out), instantiated twice (u0, u1).

Test Plan:
- data_in=62'h0, out_ready=1 -> next cycle out_valid=1, parity_out=8'h00, ecc_fault=0.
- data_in=62'h1 -> parity_out=8'h83. Round-trip 1000 random beats through the decoder -> no sbit/dbit errors.
- out_ready=0 for 5 cycles with in_valid=1 -> first beat held stable, in_ready=0. Release -> beats delivered in order, none lost or duplicated.
- Force u1 parity bit 3 for one beat of 62'h1 with detc_en=1 -> parity_out=8'h80, ecc_fault=1 on that beat, sticky=1, cnt=1. Decoder reports dbit_err. Same with detc_en=0 -> parity_out=8'h83, no fault.
- 300 forced faults -> fault_cnt=255. fault_clr coinciding with a fault -> sticky=0, cnt=0.
- ECC_62_ERR_INJ_EN: arm mode 01, pos 5 -> decoder sbit_err and corrected data. Arm mode 10, pos 61 -> bits 61 and 0 flipped, decoder dbit_err. Assert rst_n low with out_valid=1 -> out_valid=0 immediately.
